fetch_queue: RTL and testbench

Instruction fetch stage sitting directly upstream of the decoder (`ctrl`): generates instruction addresses into the `ram` instruction port and buffers returned words in a small FIFO. It presents them downstream with a valid/ready handshake. Branch/jump redirects from execute flush the queue and discard any in-flight read. This decouples decode stalls from the one-cycle synchronous instruction memory.

---
 rtl/fetch_queue.sv | 156 +++++++++++++++
 tb/tb_fetch_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage placed in front of the decoder.
// It drives addresses into a synchronous instruction memory with one
// cycle of read latency and keeps the returned words, tagged with their
// byte addresses, in a small FIFO. A redirect flushes the FIFO, drops
// any read still in flight and restarts fetching at the new address.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   Defined  : a redirect to an address that is not word aligned raises
//              a sticky trap and stops fetching. The next aligned
//              redirect clears the trap and fetching resumes.
//   Undefined: trap is tied to 0 and redirect_addr[1:0] is ignored.
//
// Downstream handshake: inst_valid/inst/inst_pc describe the FIFO head.
// A transfer happens on a rising edge where inst_valid && inst_ready.
// inst_valid never depends on inst_ready. The head stays unchanged
// until it is accepted or a redirect flushes the queue.

`timescale 1ns/1ps

module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AW       = 14,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] i_addr,
    input  logic [31:0]   i_data,
    input  logic          redirect_en,
    input  logic [AW-1:0] redirect_addr,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic [AW-1:0] inst_pc,
    output logic          trap
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] PC_STEP   = AW'(4);
    localparam logic [AW-1:0] PC_RESET  = AW'(RESET_PC);
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [AW-1:0] fetch_pc;
    logic          pending;
    logic [AW-1:0] pending_pc;

    logic [31:0]   word_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [AW-1:0] redirect_pc;
    logic          misaligned;
    logic [CW:0]   occupancy;
    logic          issue_ok;
    logic          push;
    logic          pop;

    // Redirect targets are always word aligned; the low two bits are not used for fetching.
    assign redirect_pc = {redirect_addr[AW-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q;

    assign misaligned = redirect_en && (redirect_addr[1:0] != 2'b00);

    // Trap is set by a misaligned redirect and held until the next redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_q <= 1'b0;
        end else if (redirect_en) begin
            trap_q <= misaligned;
        end
    end

    assign trap = trap_q;
`else
    logic unused_low_bits;

    assign unused_low_bits = ^redirect_addr[1:0];
    assign misaligned      = 1'b0;
    assign trap            = 1'b0;
`endif

    // Buffered words plus the read in flight must leave room for one more
    // response. The current count is used, so a same-cycle pop does not
    // make room until the next cycle.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending};
    assign issue_ok  = (occupancy < DEPTH_LIM) && !trap;

    // Memory reads every cycle. The address is harmless when no read is issued.
    assign i_addr = redirect_en ? redirect_pc : fetch_pc;

    // A response that arrives in a redirect cycle belongs to the old path.
    assign push = pending && !redirect_en;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_valid ? word_mem[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

    // Fetch address and in-flight read tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc   <= PC_RESET;
            pending    <= 1'b0;
            pending_pc <= '0;
        end else if (redirect_en) begin
            pending    <= !misaligned;
            pending_pc <= redirect_pc;
            fetch_pc   <= redirect_pc + PC_STEP;
        end else begin
            pending <= issue_ok;
            if (issue_ok) begin
                fetch_pc   <= fetch_pc + PC_STEP;
                pending_pc <= fetch_pc;
            end
        end
    end

    // FIFO pointers and occupancy. A redirect empties the queue after any same-cycle handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_en) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. Contents are only visible through the valid-gated head outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= i_data;
            pc_mem[wr_ptr]   <= pending_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed vector table, hand-written corner
// sequences and a randomized run. Each cycle is checked against a
// queue-based reference model of the fetch stage.

`timescale 1ns/1ps

module tb_fetch_queue;

  localparam int AW    = 14;
  localparam int DEPTH = 4;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_data = '0;
  logic          redirect_en = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          trap;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .redirect_en  (redirect_en),
    .redirect_addr(redirect_addr),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .trap         (trap)
  );

  // instruction memory contents: a tag in the top byte plus the address
  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    return 32'hAB00_0000 | {18'b0, a};
  endfunction

  // one-cycle synchronous read memory
  always @(posedge clk) i_data <= memf(i_addr);

  // reference model state: pcs buffered, pc in flight, next sequential pc
  logic [AW-1:0] m_q[$];
  logic [AW-1:0] m_fl[$];
  logic [AW-1:0] m_next;
  bit            m_trap;

  // per-cycle observations and log of handshaked pcs
  bit            obs_valid;
  logic [AW-1:0] obs_pc;
  logic [AW-1:0] obs_iaddr;
  logic          obs_trap;
  logic [AW-1:0] consumed[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mis(input logic [AW-1:0] a);
    return TRAP_EN && (a[1:0] != 2'b00);
  endfunction

  // driver: apply inputs for one cycle, compare against the model, advance the model
  task automatic cycle(input bit rdy, input bit ren, input logic [AW-1:0] raddr);
    logic [AW-1:0] ra;
    int occ;
    bit exp_v;
    bit mis;
    inst_ready    = rdy;
    redirect_en   = ren;
    redirect_addr = raddr;
    ra  = {raddr[AW-1:2], 2'b00};
    mis = ren && is_mis(raddr);
    @(negedge clk);
    obs_valid = inst_valid;
    obs_pc    = inst_pc;
    obs_iaddr = i_addr;
    obs_trap  = trap;
    exp_v = (m_q.size() != 0);
    check("inst_valid", 32'(inst_valid), 32'(exp_v));
    if (exp_v) begin
      check("inst_pc", 32'(inst_pc), 32'(m_q[0]));
      check("inst", inst, memf(m_q[0]));
    end
    if (!mis && !(m_trap && !ren)) check("i_addr", 32'(i_addr), 32'(ren ? ra : m_next));
    check("trap", 32'(trap), 32'(m_trap));
    @(posedge clk);
    occ = m_q.size() + m_fl.size();
    if (obs_valid && rdy) consumed.push_back(obs_pc);
    if (exp_v && rdy) void'(m_q.pop_front());
    if (ren) begin
      m_q.delete();
      m_fl.delete();
      m_trap = mis;
      if (!mis) begin
        m_fl.push_back(ra);
        m_next = ra + AW'(4);
      end
    end else begin
      if (m_fl.size() != 0) m_q.push_back(m_fl.pop_front());
      if (occ < DEPTH && !m_trap) begin
        m_fl.push_back(m_next);
        m_next = m_next + AW'(4);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    inst_ready    = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = '0;
    m_q.delete();
    m_fl.delete();
    m_next = '0;
    m_trap = 1'b0;
    consumed.delete();
    @(negedge clk);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", 32'(inst_pc), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_i_addr", 32'(i_addr), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    bit            rst;
    bit            rdy;
    bit            ren;
    logic [AW-1:0] raddr;
    bit            ev;
    logic [AW-1:0] epc;
    logic [AW-1:0] eia;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit rdy, input bit ev, input int epc, input int eia);
    vec_t v;
    v.rst   = rst;
    v.rdy   = rdy;
    v.ren   = 1'b0;
    v.raddr = '0;
    v.ev    = ev;
    v.epc   = AW'(epc);
    v.eia   = AW'(eia);
    tbl.push_back(v);
  endtask

  initial begin
    int hits;
    bit rdy;
    bit ren;
    logic [AW-1:0] raddr;

    // stream from reset with ready held high: first valid two cycles after release
    add(1, 1, 0, 0,    'h0);
    add(0, 1, 0, 0,    'h4);
    add(0, 1, 1, 'h0,  'h8);
    add(0, 1, 1, 'h4,  'hC);
    add(0, 1, 1, 'h8,  'h10);
    add(0, 1, 1, 'hC,  'h14);
    add(0, 1, 1, 'h10, 'h18);
    add(0, 1, 1, 'h14, 'h1C);
    // ready low for ten cycles: four entries buffered, address frozen at 0x10
    add(1, 0, 0, 0,    'h0);
    add(0, 0, 0, 0,    'h4);
    add(0, 0, 1, 'h0,  'h8);
    add(0, 0, 1, 'h0,  'hC);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 'h0, 'h10);
    // ready high again: pcs drain back-to-back, issue resumes after the first pop
    add(0, 1, 1, 'h0,  'h10);
    add(0, 1, 1, 'h4,  'h10);
    add(0, 1, 1, 'h8,  'h14);
    add(0, 1, 1, 'hC,  'h18);
    add(0, 1, 1, 'h10, 'h1C);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      cycle(tbl[i].rdy, tbl[i].ren, tbl[i].raddr);
      check("tbl_valid", 32'(obs_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) check("tbl_pc", 32'(obs_pc), 32'(tbl[i].epc));
      check("tbl_i_addr", 32'(obs_iaddr), 32'(tbl[i].eia));
    end

    // redirect while three entries are buffered and a read is in flight
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 14'h100);
    check("redir_i_addr", 32'(obs_iaddr), 32'h100);
    cycle(1'b1, 1'b0, '0);
    check("redir_dead", 32'(obs_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    check("redir_first_valid", 32'(obs_valid), 32'd1);
    check("redir_first_pc", 32'(obs_pc), 32'h100);
    cycle(1'b1, 1'b0, '0);
    check("redir_second_pc", 32'(obs_pc), 32'h104);
    check("redir_no_stale", 32'(consumed.size()), 32'd2);

    // address wrap at the top of the address space, without a bubble
    do_reset();
    cycle(1'b1, 1'b1, 14'h3FF8);
    cycle(1'b1, 1'b0, '0);
    check("wrap_i_addr_top", 32'(obs_iaddr), 32'h3FFC);
    cycle(1'b1, 1'b0, '0);
    check("wrap_i_addr_zero", 32'(obs_iaddr), 32'h0);
    cycle(1'b1, 1'b0, '0);
    check("wrap_pc_top", 32'(obs_pc), 32'h3FFC);
    cycle(1'b1, 1'b0, '0);
    check("wrap_valid", 32'(obs_valid), 32'd1);
    check("wrap_pc_zero", 32'(obs_pc), 32'h0);

    // redirect in the same cycle as a completed handshake
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 14'h100);
    check("hs_head_pc", 32'(obs_pc), 32'h8);
    repeat (3) cycle(1'b1, 1'b0, '0);
    hits = 0;
    foreach (consumed[i]) if (consumed[i] == 14'h8) hits++;
    check("hs_consumed_once", 32'(hits), 32'd1);
    check("hs_consumed_len", 32'(consumed.size()), 32'd5);
    if (consumed.size() > 3) check("hs_next_head", 32'(consumed[3]), 32'h100);

    // misaligned redirect
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 14'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    cycle(1'b1, 1'b0, '0);
    check("mis_trap_set", 32'(obs_trap), 32'd1);
    check("mis_no_valid", 32'(obs_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    check("mis_trap_held", 32'(obs_trap), 32'd1);
    check("mis_still_empty", 32'(obs_valid), 32'd0);
    cycle(1'b1, 1'b1, 14'h200);
    cycle(1'b1, 1'b0, '0);
    check("mis_trap_clear", 32'(obs_trap), 32'd0);
    cycle(1'b1, 1'b0, '0);
    check("mis_resume_valid", 32'(obs_valid), 32'd1);
    check("mis_resume_pc", 32'(obs_pc), 32'h200);
`else
    cycle(1'b1, 1'b0, '0);
    check("mis_no_trap", 32'(obs_trap), 32'd0);
    check("mis_dead", 32'(obs_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    check("mis_aligned_valid", 32'(obs_valid), 32'd1);
    check("mis_aligned_pc", 32'(obs_pc), 32'h100);
`endif

    // randomized traffic against the reference model, with a reset mid-run
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      if ((i % 200) < 40) rdy = ($urandom_range(0, 5) == 0);
      else                rdy = ($urandom_range(0, 3) != 0);
      ren = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) raddr = AW'(14'h3FF0 + $urandom_range(0, 15));
      else                           raddr = AW'($urandom_range(0, 16383));
      cycle(rdy, ren, raddr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
